// File: rtl/srwpl_seq_ctrl.sv
// Command sequencer in front of the SrWPL shift register: load a word, shift it
// a clamped number of steps, capture the register contents and return them.
module srwpl_seq_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_data,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_count,
  input  logic          cmd_fill,
  output logic [1:0]    selection,
  output logic [N-1:0]  data_in,
  output logic          i_right,
  output logic          i_left,
  input  logic [N-1:0]  sr_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE,
    RESULT
  } state_t;

  localparam logic [CW-1:0] N_STEPS = CW'(N);

  state_t        state, state_d;
  logic [CW-1:0] steps, steps_d;
  logic          dir, dir_d;
  logic          fill, fill_d;
  logic [1:0]    sel_d;
  logic [N-1:0]  data_in_d;
  logic          i_right_d, i_left_d;
  logic          res_valid_d;
  logic [N-1:0]  res_data_d;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // SrWPL pin values are computed one state ahead so they are registered
  // and already valid for the whole cycle of the state that uses them.
  always_comb begin
    state_d     = state;
    steps_d     = steps;
    dir_d       = dir;
    fill_d      = fill;
    sel_d       = selection;
    data_in_d   = data_in;
    i_right_d   = i_right;
    i_left_d    = i_left;
    res_valid_d = res_valid;
    res_data_d  = res_data;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          steps_d   = (cmd_count > N_STEPS) ? N_STEPS : cmd_count;
          dir_d     = cmd_dir;
          fill_d    = cmd_fill;
          sel_d     = 2'd1;
          data_in_d = cmd_data;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (steps != '0) begin
          sel_d     = dir ? 2'd3 : 2'd2;
          i_right_d = ~dir & fill;
          i_left_d  = dir & fill;
          state_d   = SHIFT;
        end else begin
          sel_d   = 2'd0;
          state_d = CAPTURE;
        end
      end
      SHIFT: begin
        steps_d = steps - CW'(1);
        if (steps == CW'(1)) begin
          sel_d     = 2'd0;
          i_right_d = 1'b0;
          i_left_d  = 1'b0;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        res_data_d  = sr_data;
        res_valid_d = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      steps     <= '0;
      dir       <= 1'b0;
      fill      <= 1'b0;
      selection <= '0;
      data_in   <= '0;
      i_right   <= 1'b0;
      i_left    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_d;
      steps     <= steps_d;
      dir       <= dir_d;
      fill      <= fill_d;
      selection <= sel_d;
      data_in   <= data_in_d;
      i_right   <= i_right_d;
      i_left    <= i_left_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
    end
  end

endmodule
